logic_reduce_unit: RTL and testbench

Parametrised, registered successor to the team's two-input gate primitives. Reduces N input channels of WIDTH bits each to one WIDTH-bit word with a run-time selectable bitwise operator: AND, OR, XOR, NAND, NOR or XNOR. An optional accumulate mode folds successive beats into one result per frame. Valid/ready handshakes sit on both sides, so the block drops into streaming datapaths between producer and consumer stages.

---
 rtl/logic_reduce_unit.sv | 108 ++++++++++
 tb/tb_logic_reduce_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_reduce_unit.sv
// Registered N-channel bitwise reducer with selectable AND/OR/XOR (optionally inverted)
// operator, optional per-frame accumulation and valid/ready handshakes on both sides.
module logic_reduce_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_last,
    input  logic [2:0]         op,
    input  logic               acc_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last
);

    typedef enum logic {StIdle, StAcc} state_t;
    typedef enum logic [1:0] {BaseAnd, BaseOr, BaseXor} base_t;

    state_t           state;
    logic [2:0]       op_q;
    logic             acc_en_q;
    logic [WIDTH-1:0] acc_q;

    logic [2:0]       eff_op;
    logic             eff_acc;
    base_t            base;
    logic             invert;
    logic             accept;
    logic [WIDTH-1:0] beat_red;
    logic [WIDTH-1:0] fold;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] apply_base(input base_t b, input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] c);
        case (b)
            BaseAnd: return a & c;
            BaseXor: return a ^ c;
            default: return a | c;
        endcase
    endfunction

    assign in_ready = !reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // The first beat of a frame uses the live controls; later beats use the latched ones.
    assign eff_op  = (state == StIdle) ? op : op_q;
    assign eff_acc = (state == StIdle) ? acc_en : acc_en_q;

    always_comb begin
        case (eff_op)
            3'b000, 3'b011: base = BaseAnd;
            3'b010, 3'b101: base = BaseXor;
            default:        base = BaseOr;
        endcase
        invert = (eff_op == 3'b011) || (eff_op == 3'b100) || (eff_op == 3'b101);

        beat_red = in_data[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            beat_red = apply_base(base, beat_red, in_data[k*WIDTH +: WIDTH]);
        end

        // The accumulator is kept un-inverted; inversion only happens on the way out.
        fold   = (state == StAcc) ? apply_base(base, acc_q, beat_red) : beat_red;
        result = invert ? ~fold : fold;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            op_q      <= 3'b001;
            acc_en_q  <= 1'b0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (state == StIdle) begin
                    op_q     <= op;
                    acc_en_q <= acc_en;
                end
                if (!eff_acc) begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    out_last  <= in_last;
                end else if (!in_last) begin
                    acc_q <= fold;
                    state <= StAcc;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    out_last  <= 1'b1;
                    acc_q     <= '0;
                    state     <= StIdle;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Scoreboard bench for logic_reduce_unit: a frame-level reference model queues expected
// results on acceptance, and an independent monitor compares them as the DUT emits.
module tb_logic_reduce_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  op;
    logic        acc_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    int checks = 0;
    int errs   = 0;

    logic [8:0]  exp_q[$];
    logic [31:0] frame_beats[$];
    logic        in_frame = 1'b0;
    logic [2:0]  f_op;
    logic        f_acc;
    logic        rand_rdy = 1'b0;

    logic_reduce_unit #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .op        (op),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole frame reduced at once over every channel of every beat.
    function automatic logic [7:0] reduce_frame(input logic [2:0] o);
        logic [7:0] r;
        logic [7:0] ch;
        int         b;
        b = (o == 3'd0 || o == 3'd3) ? 0 : ((o == 3'd2 || o == 3'd5) ? 2 : 1);
        r = (b == 0) ? 8'hFF : 8'h00;
        foreach (frame_beats[i]) begin
            for (int k = 0; k < 4; k++) begin
                ch = frame_beats[i][k*8 +: 8];
                if (b == 0)      r = r & ch;
                else if (b == 1) r = r | ch;
                else             r = r ^ ch;
            end
        end
        if (o == 3'd3 || o == 3'd4 || o == 3'd5) r = ~r;
        return r;
    endfunction

    task automatic model_accept(input logic [31:0] data, input logic last, input logic [2:0] o,
                                input logic acc, output logic produces);
        if (!in_frame) begin
            f_op  = o;
            f_acc = acc;
            frame_beats.delete();
            in_frame = 1'b1;
        end
        frame_beats.push_back(data);
        produces = !f_acc || last;
        if (produces) begin
            exp_q.push_back({last, reduce_frame(f_op)});
            in_frame = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] data, input logic last, input logic [2:0] o,
                        input logic acc);
        int   waited;
        logic rdy;
        logic produces;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        op       = o;
        acc_en   = acc;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 at %0t", $time);
            in_valid = 1'b0;
            return;
        end
        rdy = out_ready;
        model_accept(data, last, o, acc, produces);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (produces)  check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        else if (rdy)  check("no_out_mid_frame", {31'd0, out_valid}, 32'd0);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", out_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                check("out_last", {31'd0, out_last}, {31'd0, e[8]});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        op        = 3'b001;
        acc_en    = 1'b0;
        out_ready = 1'b1;

        // 1. Reset behaviour
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", {24'd0, out_data}, 32'd0);
        check("reset_out_last", {31'd0, out_last}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // 2. Non-accumulate sweep on {01,02,04,08}
        send(32'h01020408, 1'b0, 3'b001, 1'b0);
        send(32'h01020408, 1'b1, 3'b100, 1'b0);
        send(32'h01020408, 1'b0, 3'b000, 1'b0);
        send(32'h01020408, 1'b1, 3'b110, 1'b0);

        // 3. XOR / XNOR / NAND
        send(32'hFF0FF000, 1'b1, 3'b010, 1'b0);
        send(32'hFF0FF000, 1'b0, 3'b101, 1'b0);
        send(32'hFFFFFFFF, 1'b1, 3'b011, 1'b0);

        // 4. Accumulate OR frame; mid-frame op/acc_en changes must be ignored
        send(32'h00000001, 1'b0, 3'b001, 1'b1);
        send(32'h00100000, 1'b0, 3'b000, 1'b1);
        send(32'h80000000, 1'b1, 3'b000, 1'b0);
        @(posedge clk);
        #1;

        // 5. Backpressure
        out_ready = 1'b0;
        send(32'h01020408, 1'b0, 3'b001, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h000000F0;
        in_last  = 1'b1;
        op       = 3'b001;
        acc_en   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_data_hold", {24'd0, out_data}, 32'h0F);
            check("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h000000F0, 1'b1, 3'b001, 1'b0);
        @(posedge clk);
        #1;

        // 6. Reset mid-frame discards the partial XOR accumulation
        send(32'h0000000F, 1'b0, 3'b010, 1'b1);
        send(32'h000000F0, 1'b0, 3'b010, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        frame_beats.delete();
        in_frame = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        send(32'h00000033, 1'b1, 3'b010, 1'b1);

        // Randomised phase with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        if (in_frame) send($urandom, 1'b1, f_op, 1'b1);

        for (int w = 0; w < 50 && (exp_q.size() != 0 || out_valid); w++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
